// File: rtl/uart_rx_if.sv
// ----------------------------------------------------------------------------
// uart_rx_if
// Result bundle of the UART receiver, consumed by the host command interface.
//
// Signals:
//   o_rx_done     one-cycle strobe: o_rx_data holds a newly received good byte
//   o_rx_data     last good byte (DBIT wide), held until the next good byte
//   o_frame_err   one-cycle strobe: stop bit sampled low
//   o_busy        receiver is somewhere other than IDLE
//   o_parity_err  one-cycle strobe: even parity check failed (only when
//                 UART_RX_PARITY_EN is defined)
//
// Modports:
//   master  the receiver, drives every signal
//   slave   the consumer, reads every signal
// ----------------------------------------------------------------------------
interface uart_rx_if #(
  parameter int DBIT = 8
);

  logic            o_rx_done;
  logic [DBIT-1:0] o_rx_data;
  logic            o_frame_err;
  logic            o_busy;
`ifdef UART_RX_PARITY_EN
  logic            o_parity_err;
`endif

  modport master (
`ifdef UART_RX_PARITY_EN
    output o_parity_err,
`endif
    output o_rx_done,
    output o_rx_data,
    output o_frame_err,
    output o_busy
  );

  modport slave (
`ifdef UART_RX_PARITY_EN
    input  o_parity_err,
`endif
    input  o_rx_done,
    input  o_rx_data,
    input  o_frame_err,
    input  o_busy
  );

endinterface

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// UART receiver using a 16x (OS_RATE) oversampling tick from the shared
// baud-rate generator. Frame: 1 start bit, DBIT data bits LSB first, an
// optional even parity bit, then a stop period of SB_TICK ticks.
//
// Configuration macro: UART_RX_PARITY_EN adds the PARITY state and the
// o_parity_err strobe on the interface.
//
// Ports:
//   i_clk      system clock, rising edge
//   i_reset_n  asynchronous active-low reset
//   i_s_tick   oversampling enable, one i_clk cycle wide, OS_RATE per bit
//   i_rx       serial line, idle high, asynchronous to i_clk
//   rx_bus     uart_rx_if.master: done/data/frame_err/busy(/parity_err)
// ----------------------------------------------------------------------------
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int OS_RATE = 16
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_s_tick,
  input  logic        i_rx,
  uart_rx_if.master   rx_bus
);

  // The tick counter must reach the longer of a bit period and the stop period.
  localparam int CNT_MAX = (OS_RATE > SB_TICK) ? OS_RATE : SB_TICK;
  localparam int TW      = $clog2(CNT_MAX);
  localparam int BW      = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [TW-1:0] MID_TICK  = TW'(OS_RATE / 2 - 1);
  localparam logic [TW-1:0] BIT_TICK  = TW'(OS_RATE - 1);
  localparam logic [TW-1:0] STOP_TICK = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DBIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef UART_RX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP
  } state_t;

  state_t          state;
  logic [TW-1:0]   tick_cnt;
  logic [BW-1:0]   bit_cnt;
  logic [DBIT-1:0] shift_reg;
  logic            rx_meta;
  logic            rx_sync;
  logic            rx_prev;
`ifdef UART_RX_PARITY_EN
  logic            parity_bit;
`endif

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  // Reset to the idle level so release of reset never looks like a start edge.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receive FSM. All outputs are registered here; the strobes default low so
  // each one lasts exactly one cycle. Only an edge (not a low level) leaves
  // IDLE, so a held break cannot retrigger reception.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state              <= ST_IDLE;
      tick_cnt           <= '0;
      bit_cnt            <= '0;
      shift_reg          <= '0;
      rx_bus.o_rx_done   <= 1'b0;
      rx_bus.o_rx_data   <= '0;
      rx_bus.o_frame_err <= 1'b0;
      rx_bus.o_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rx_bus.o_parity_err <= 1'b0;
      parity_bit          <= 1'b0;
`endif
    end else begin
      rx_bus.o_rx_done   <= 1'b0;
      rx_bus.o_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rx_bus.o_parity_err <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (rx_prev && !rx_sync) begin
            state         <= ST_START;
            tick_cnt      <= '0;
            rx_bus.o_busy <= 1'b1;
          end
        end

        ST_START: begin
          if (i_s_tick) begin
            if (tick_cnt == MID_TICK) begin
              if (!rx_sync) begin
                state    <= ST_DATA;
                tick_cnt <= '0;
                bit_cnt  <= '0;
              end else begin
                state         <= ST_IDLE;
                rx_bus.o_busy <= 1'b0;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        ST_DATA: begin
          if (i_s_tick) begin
            if (tick_cnt == BIT_TICK) begin
              tick_cnt  <= '0;
              shift_reg <= {rx_sync, shift_reg[DBIT-1:1]};
              if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                state <= ST_PARITY;
`else
                state <= ST_STOP;
`endif
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (i_s_tick) begin
            if (tick_cnt == BIT_TICK) begin
              tick_cnt   <= '0;
              parity_bit <= rx_sync;
              state      <= ST_STOP;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end
`endif

        ST_STOP: begin
          if (i_s_tick) begin
            if (tick_cnt == STOP_TICK) begin
              state         <= ST_IDLE;
              tick_cnt      <= '0;
              rx_bus.o_busy <= 1'b0;
              // A bad stop bit wins over any parity result.
              if (!rx_sync) begin
                rx_bus.o_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
              end else if ((^shift_reg) ^ parity_bit) begin
                rx_bus.o_parity_err <= 1'b1;
`endif
              end else begin
                rx_bus.o_rx_data <= shift_reg;
                rx_bus.o_rx_done <= 1'b1;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        default: begin
          state         <= ST_IDLE;
          rx_bus.o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver sitting directly upstream of the host command interface.
- Deserialises the serial line into DBIT-wide bytes using a 16x oversampling tick from the shared baud-rate generator.
- Presents each good byte with a one-cycle done strobe. That strobe/data pair drives the interface's rx_done/rx_data inputs.
- Frame is 1 start bit, DBIT data bits (LSB first), optional parity, and stop bit(s) lasting SB_TICK ticks.

Parameters:
- DBIT, 8: data bits per frame.
- SB_TICK, 16: oversampling ticks in the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2).
- OS_RATE, 16: oversampling ticks per bit. Must be even and ≥ 8.

Ports:
- i_clk  in  1  system clock; all logic on its rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_s_tick  in  1  oversampling enable pulse, one i_clk cycle wide, OS_RATE per bit time.
- i_rx  in  1  serial line; idle high; asynchronous to i_clk.
- o_rx_done  out  1  one-cycle pulse: o_rx_data holds a newly received good byte.
- o_rx_data  out  DBIT  last good byte; held until the next good byte.
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low.
- o_busy  out  1  high while in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release) sets:
  - o_rx_done=0, o_rx_data=0, o_frame_err=0, o_busy=0;
  - state=IDLE, tick counter=0, bit counter=0, shift register=0.
  - Reset mid-frame aborts the frame; no strobe is issued afterwards.
- i_rx passes through a 2-flop synchroniser (reset value 1), plus one further flop for edge detect.
- All sampling uses the synchronised value.
- Counters advance only in cycles where i_s_tick=1.
- IDLE:
  - A falling edge (previous sync=1, current sync=0) moves to START with the tick counter cleared.
  - A constant-low line (break) does not retrigger.
- START:
  - At tick count OS_RATE/2-1 (mid start bit): if line is 0, go to DATA with both counters cleared.
  - If line is 1, treat as a glitch: return to IDLE with no outputs.
- DATA:
  - At tick count OS_RATE-1, shift the line into the MSB of the shift register (right shift, so LSB-first reception) and clear the tick counter.
  - After bit DBIT-1, go to PARITY (feature enabled) or STOP.
- STOP:
  - At tick count SB_TICK-1, sample the line.
  - 1: o_rx_data ← shift register and o_rx_done=1 in the same cycle, both registered.
  - 0: o_frame_err=1, o_rx_data unchanged, no done pulse.
  - Either way, return to IDLE.
- Latency: o_rx_done rises within 3 i_clk cycles of the i_s_tick that samples the stop bit.
- o_rx_done and o_frame_err are never high together and are never high for more than one cycle.
- Back-to-back frames: a falling edge in the IDLE cycle immediately after STOP starts the next frame; no idle gap is required.
- i_s_tick held low: the FSM freezes in its current state; no timeout.
- o_busy = (state != IDLE), registered.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, sampling one bit at tick OS_RATE-1.
  - Parity is even: XOR of the data bits and the parity bit must be 0.
  - Adds output o_parity_err (1 bit, reset 0). It pulses for one cycle in place of o_rx_done when the parity check fails and the stop bit is good. o_rx_data is not updated in that case.
  - A bad stop bit takes priority: o_frame_err only.
- Not defined:
  - No PARITY state and no o_parity_err port.
  - Frame is start + DBIT + stop.

Test Plan:
- i_s_tick every 4 clocks; send 0x64 (start, bits 0,0,1,0,0,1,1,0, stop) -> exactly one o_rx_done pulse, o_rx_data=0x64, o_frame_err never high, o_busy falls in the same cycle done rises.
- Back-to-back 0x6F then 0x2B with no idle gap -> two done pulses; o_rx_data=0x6F after the first, 0x2B after the second.
- i_rx low for 5 ticks then high (glitch) -> returns to IDLE, no done/frame_err pulse, o_rx_data keeps its prior value (0x2B).
- Send 0xA5 with stop bit forced 0 -> one o_frame_err pulse, no o_rx_done, o_rx_data unchanged.
- Hold i_rx low for 40 bit times (break), then release -> one o_frame_err only; the next valid frame 0x11 is received correctly.
- Assert i_reset_n=0 during data bit 3 of 0x5A, release, then send 0x33 -> all outputs 0 during reset, no strobe for 0x5A, then done with o_rx_data=0x33.
- With UART_RX_PARITY_EN: 0x07 with parity bit 1 -> o_rx_done with data 0x07; same byte with parity bit 0 -> o_parity_err pulse, no done, o_rx_data stays 0x07.
